// File: rtl/health_pkg.sv
// Shared types and constants for the health bar controller.
package health_pkg;

    localparam int HEALTH_W    = 9;
    localparam int FULL_HEALTH = 200;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIGHT = 2'd1,
        ST_KO    = 2'd2
    } state_t;

    localparam logic WINNER_P1 = 1'b0;
    localparam logic WINNER_P2 = 1'b1;

    localparam logic PTR_P1 = 1'b0;

    function automatic logic [HEALTH_W-1:0] sat_sub(
        input logic [HEALTH_W-1:0] health,
        input logic [HEALTH_W-1:0] dmg
    );
        return (dmg >= health) ? '0 : health - dmg;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: one-cycle pulse every DIV clocks, cleared only by reset.
module tick_divider #(
    parameter int DIV = 250000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DIV - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == CW'(DIV - 1));

endmodule

// File: rtl/health_ctrl.sv
// Round controller for both health bars: round-robin hit arbitration, saturating damage, KO.
// Optional per-player post-hit invulnerability when HEALTH_INVULN_EN is defined.
//   state | meaning
//   IDLE  | no round yet, requests ignored
//   FIGHT | acked hits damage the target player
//   KO    | round over, hits acked and discarded
module health_ctrl
    import health_pkg::*;
#(
    parameter int FULL_HEALTH = health_pkg::FULL_HEALTH,
    parameter int DMG_W       = 6,
    parameter int DROP_DIV    = 250000
`ifdef HEALTH_INVULN_EN
    ,
    parameter int INVULN_CYCLES = 1000000
`endif
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_round_start,
    input  logic                i_hit_req_p1,
    input  logic [DMG_W-1:0]    i_dmg_p1,
    output logic                o_hit_ack_p1,
    input  logic                i_hit_req_p2,
    input  logic [DMG_W-1:0]    i_dmg_p2,
    output logic                o_hit_ack_p2,
    output logic [HEALTH_W-1:0] o_health_p1,
    output logic [HEALTH_W-1:0] o_health_p2,
    output logic                o_ko,
    output logic                o_winner,
    output logic                o_drop_tick
);

    state_t              r_state;
    logic [HEALTH_W-1:0] r_health_p1;
    logic [HEALTH_W-1:0] r_health_p2;
    logic                r_ko;
    logic                r_winner;
    logic                r_ptr;

    logic                w_live;
    logic                w_both;
    logic                w_ack_p1;
    logic                w_ack_p2;
    logic                w_shield_p1;
    logic                w_shield_p2;
    logic                w_hit_p1;
    logic                w_hit_p2;
    logic [HEALTH_W-1:0] w_dmg_p1;
    logic [HEALTH_W-1:0] w_dmg_p2;
    logic [HEALTH_W-1:0] w_next_p1;
    logic [HEALTH_W-1:0] w_next_p2;

    // round_start wins over any request in the same cycle
    assign w_live   = (r_state != ST_IDLE) && !i_round_start;
    assign w_both   = i_hit_req_p1 && i_hit_req_p2;
    assign w_ack_p1 = w_live && i_hit_req_p1 && (!i_hit_req_p2 || (r_ptr == PTR_P1));
    assign w_ack_p2 = w_live && i_hit_req_p2 && (!i_hit_req_p1 || (r_ptr != PTR_P1));

    assign w_dmg_p1  = HEALTH_W'(i_dmg_p1);
    assign w_dmg_p2  = HEALTH_W'(i_dmg_p2);
    assign w_next_p1 = sat_sub(r_health_p1, w_dmg_p1);
    assign w_next_p2 = sat_sub(r_health_p2, w_dmg_p2);

    assign w_hit_p1 = w_ack_p1 && (r_state == ST_FIGHT) && (w_dmg_p1 != '0) && !w_shield_p1;
    assign w_hit_p2 = w_ack_p2 && (r_state == ST_FIGHT) && (w_dmg_p2 != '0) && !w_shield_p2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_health_p1 <= '0;
            r_health_p2 <= '0;
            r_ko        <= 1'b0;
            r_winner    <= WINNER_P1;
            r_ptr       <= PTR_P1;
        end else if (i_round_start) begin
            r_state     <= ST_FIGHT;
            r_health_p1 <= HEALTH_W'(FULL_HEALTH);
            r_health_p2 <= HEALTH_W'(FULL_HEALTH);
            r_ko        <= 1'b0;
            r_ptr       <= PTR_P1;
        end else begin
            if (w_both && (r_state != ST_IDLE)) begin
                r_ptr <= ~r_ptr;
            end
            if (w_hit_p1) begin
                r_health_p1 <= w_next_p1;
                if (w_next_p1 == '0) begin
                    r_ko     <= 1'b1;
                    r_winner <= WINNER_P2;
                    r_state  <= ST_KO;
                end
            end else if (w_hit_p2) begin
                r_health_p2 <= w_next_p2;
                if (w_next_p2 == '0) begin
                    r_ko     <= 1'b1;
                    r_winner <= WINNER_P1;
                    r_state  <= ST_KO;
                end
            end
        end
    end

`ifdef HEALTH_INVULN_EN
    localparam int INV_W = $clog2(INVULN_CYCLES + 1);

    logic [INV_W-1:0] r_inv_p1;
    logic [INV_W-1:0] r_inv_p2;

    assign w_shield_p1 = (r_inv_p1 != '0);
    assign w_shield_p2 = (r_inv_p2 != '0);

    // Only applied hits reload; a discarded hit does not extend the window
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inv_p1 <= '0;
            r_inv_p2 <= '0;
        end else if (i_round_start) begin
            r_inv_p1 <= '0;
            r_inv_p2 <= '0;
        end else begin
            r_inv_p1 <= w_hit_p1 ? INV_W'(INVULN_CYCLES) : (w_shield_p1 ? r_inv_p1 - 1'b1 : '0);
            r_inv_p2 <= w_hit_p2 ? INV_W'(INVULN_CYCLES) : (w_shield_p2 ? r_inv_p2 - 1'b1 : '0);
        end
    end
`else
    assign w_shield_p1 = 1'b0;
    assign w_shield_p2 = 1'b0;
`endif

    tick_divider #(
        .DIV (DROP_DIV)
    ) u_drop_div (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_tick  (o_drop_tick)
    );

    assign o_hit_ack_p1 = w_ack_p1;
    assign o_hit_ack_p2 = w_ack_p2;
    assign o_health_p1  = r_health_p1;
    assign o_health_p2  = r_health_p2;
    assign o_ko         = r_ko;
    assign o_winner     = r_winner;

endmodule

// File: tb/tb_health_ctrl.sv
// Bench for health_ctrl: directed scenarios then random hits against a round-level model.
module tb_health_ctrl;

    localparam int DIV  = 7;
    localparam int FULL = 200;
    localparam int INV  = 8;
`ifdef HEALTH_INVULN_EN
    localparam bit INV_ON = 1'b1;
`else
    localparam bit INV_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rs = 1'b0;
    logic       r1 = 1'b0;
    logic       r2 = 1'b0;
    logic [5:0] d1 = '0;
    logic [5:0] d2 = '0;
    logic       ack1, ack2, ko, winner, tick;
    logic [8:0] hp1, hp2;

    always #5 clk = ~clk;

    health_ctrl #(
        .FULL_HEALTH (FULL),
        .DMG_W       (6),
        .DROP_DIV    (DIV)
`ifdef HEALTH_INVULN_EN
        ,
        .INVULN_CYCLES (INV)
`endif
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_round_start (rs),
        .i_hit_req_p1  (r1),
        .i_dmg_p1      (d1),
        .o_hit_ack_p1  (ack1),
        .i_hit_req_p2  (r2),
        .i_dmg_p2      (d2),
        .o_hit_ack_p2  (ack2),
        .o_health_p1   (hp1),
        .o_health_p2   (hp2),
        .o_ko          (ko),
        .o_winner      (winner),
        .o_drop_tick   (tick)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // round-level model
    int m_h[2];
    int m_inv[2];
    bit m_round, m_ko, m_win, m_ptr;
    int m_n;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_h[0] = 0; m_h[1] = 0;
        m_inv[0] = 0; m_inv[1] = 0;
        m_round = 0; m_ko = 0; m_win = 0; m_ptr = 0;
    endfunction

    // One clock: drive inputs, check acks/tick, take the edge, check state.
    task automatic cyc(input bit s, input bit q1, input int dd1, input bit q2, input int dd2,
                       output bit o1, output bit o2);
        bit live, e1, e2;
        int p, d;
        int nxt[2];
        rs = s; r1 = q1; d1 = 6'(dd1); r2 = q2; d2 = 6'(dd2);
        #1;
        live = m_round && !s;
        e1 = live && q1 && (!q2 || !m_ptr);
        e2 = live && q2 && (!q1 || m_ptr);
        o1 = ack1; o2 = ack2;
        chk("ack_p1", ack1, e1);
        chk("ack_p2", ack2, e2);
        chk("drop_tick", tick, (m_n % DIV) == DIV - 1);
        @(posedge clk);
        m_n++;
        if (s) begin
            m_h[0] = FULL; m_h[1] = FULL;
            m_inv[0] = 0; m_inv[1] = 0;
            m_ko = 0; m_ptr = 0; m_round = 1;
        end else begin
            p = e1 ? 0 : (e2 ? 1 : -1);
            d = e1 ? dd1 : dd2;
            for (int i = 0; i < 2; i++) nxt[i] = (m_inv[i] > 0) ? m_inv[i] - 1 : 0;
            if (m_round && !m_ko && p >= 0) begin
                if (!(INV_ON && m_inv[p] != 0) && d > 0) begin
                    m_h[p] = (d >= m_h[p]) ? 0 : m_h[p] - d;
                    nxt[p] = INV;
                    if (m_h[p] == 0) begin
                        m_ko = 1;
                        m_win = (p == 0);
                    end
                end
            end
            m_inv = nxt;
            if (live && q1 && q2) m_ptr = !m_ptr;
        end
        #1;
        chk("health_p1", hp1, m_h[0]);
        chk("health_p2", hp2, m_h[1]);
        chk("ko", ko, m_ko);
        if (m_ko) chk("winner", winner, m_win);
    endtask

    task automatic idle(input int k);
        bit a, b;
        repeat (k) cyc(0, 0, 0, 0, 0, a, b);
    endtask

    task automatic release_reset();
        rs = 0; r1 = 0; r2 = 0; d1 = '0; d2 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        m_n = 1;
        #1;
    endtask

    initial begin
        bit a1, a2;
        bit pend[2];
        int pd[2];
        int amt, s;

        model_reset();
        #3;
        chk("rst_health_p1", hp1, 0);
        chk("rst_health_p2", hp2, 0);
        chk("rst_ko", ko, 0);
        chk("rst_winner", winner, 0);
        chk("rst_tick", tick, 0);
        release_reset();

        // IDLE ignores requests
        cyc(0, 1, 10, 1, 10, a1, a2);
        chk("idle_no_ack", a1 | a2, 0);
        cyc(1, 0, 0, 0, 0, a1, a2);
        chk("start_h1", hp1, 200);
        chk("start_h2", hp2, 200);

        cyc(0, 0, 0, 1, 30, a1, a2);
        chk("single_ack_p2", a2, 1);
        chk("single_h2", hp2, 170);
        chk("single_h1", hp1, 200);

        // two simultaneous pairs: pointer alternates
        cyc(0, 1, 5, 1, 5, a1, a2);
        chk("pair1_first_p1", a1, 1);
        cyc(0, 0, 0, 1, 5, a1, a2);
        chk("pair1_second_p2", a2, 1);
        cyc(0, 1, 5, 1, 5, a1, a2);
        chk("pair2_first_p2", a2, 1);
        chk("pair2_first_not_p1", a1, 0);
        cyc(0, 1, 5, 0, 0, a1, a2);
        chk("pair2_second_p1", a1, 1);

        // bring P1 down to 10, then a 25 hit KOs
        while (m_h[0] > 25) begin
            idle(9);
            amt = m_h[0] - 10;
            if (amt > 60) amt = 60;
            cyc(0, 1, amt, 0, 0, a1, a2);
        end
        chk("p1_at_10", hp1, 10);
        idle(9);
        cyc(0, 1, 25, 0, 0, a1, a2);
        chk("ko_h1", hp1, 0);
        chk("ko_flag", ko, 1);
        chk("ko_winner", winner, 1);
        amt = m_h[1];
        cyc(0, 0, 0, 1, 40, a1, a2);
        chk("ko_ack_p2", a2, 1);
        chk("ko_frozen_h2", hp2, amt);

        // round_start beats a pending hit in KO
        cyc(1, 0, 0, 1, 30, a1, a2);
        chk("restart_no_ack", a2, 0);
        chk("restart_h1", hp1, 200);
        chk("restart_h2", hp2, 200);
        chk("restart_ko", ko, 0);
        cyc(0, 0, 0, 1, 30, a1, a2);
        chk("restart_then_ack", a2, 1);
        chk("restart_hit_h2", hp2, 170);

`ifdef HEALTH_INVULN_EN
        idle(9);
        cyc(0, 1, 20, 0, 0, a1, a2);
        chk("inv_first", hp1, 180);
        idle(2);
        cyc(0, 1, 20, 0, 0, a1, a2);
        chk("inv_second_ack", a1, 1);
        chk("inv_second_discard", hp1, 180);
        idle(5);
        cyc(0, 1, 20, 0, 0, a1, a2);
        chk("inv_third", hp1, 160);
`endif

        // async reset mid-round
        cyc(0, 1, 7, 0, 0, a1, a2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_h1", hp1, 0);
        chk("async_h2", hp2, 0);
        chk("async_ko", ko, 0);
        chk("async_tick", tick, 0);
        model_reset();
        release_reset();

        // random hits and restarts
        pend[0] = 0; pend[1] = 0; pd[0] = 0; pd[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    pend[i] = ($urandom % 3) == 0;
                    pd[i] = $urandom % 64;
                end
            end
            s = m_round ? (($urandom % 80) == 0) : (($urandom % 5) == 0);
            cyc(s[0], pend[0], pd[0], pend[1], pd[1], a1, a2);
            if (a1) pend[0] = 0;
            if (a2) pend[1] = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
